// File: rtl/seg_display_cont.sv
// Eight-digit multiplexed 7-segment scanner with a double-buffered frame commit.
// Optional leading-zero suppression is enabled by defining SEG_LZ_BLANK_EN.
module seg_display_cont #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned BLANK_CYC   = 4
) (
  input  logic        CLK100_I,
  input  logic        RST_I,
  input  logic [31:0] DATA_I,
  input  logic [7:0]  DP_I,
  input  logic [7:0]  EN_I,
  input  logic        LOAD_I,
  output logic [7:0]  AN_O,
  output logic [6:0]  SEG_O,
  output logic        DP_O,
  output logic        PEND_O,
  output logic        FRAME_O
);

  localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    idx_q, idx_d;

  logic [31:0] pnd_data_q, pnd_data_d;
  logic [7:0]  pnd_dp_q, pnd_dp_d;
  logic [7:0]  pnd_en_q, pnd_en_d;
  logic        pend_q, pend_d;

  logic [31:0] act_data_q, act_data_d;
  logic [7:0]  act_dp_q, act_dp_d;
  logic [7:0]  act_en_q, act_en_d;

  logic [7:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;
  logic        dp_q, dp_d;
  logic        frame_q, frame_d;

  logic        wrap;
  logic        boundary;
  logic        blank;
  logic [3:0]  nib;
  logic [7:0]  sup;

  function automatic logic [6:0] hex_decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Scan timing: prescaler and digit index.
  always_comb begin
    wrap     = (presc_q == PW'(REFRESH_DIV - 1));
    boundary = wrap && (idx_q == 3'd7);
    blank    = (presc_q < PW'(BLANK_CYC));
    presc_d  = wrap ? '0 : presc_q + PW'(1);
    idx_d    = wrap ? idx_q + 3'd1 : idx_q;
  end

  // Pending buffer: a load always wins the buffer; the commit reads the pre-edge contents.
  always_comb begin
    pnd_data_d = pnd_data_q;
    pnd_dp_d   = pnd_dp_q;
    pnd_en_d   = pnd_en_q;
    pend_d     = pend_q;
    if (boundary) begin
      pend_d = 1'b0;
    end
    if (LOAD_I) begin
      pnd_data_d = DATA_I;
      pnd_dp_d   = DP_I;
      pnd_en_d   = EN_I;
      pend_d     = 1'b1;
    end
  end

  // Active registers only move on a frame boundary, so a frame never shows a partial update.
  always_comb begin
    act_data_d = act_data_q;
    act_dp_d   = act_dp_q;
    act_en_d   = act_en_q;
    frame_d    = boundary;
    if (boundary && pend_q) begin
      act_data_d = pnd_data_q;
      act_dp_d   = pnd_dp_q;
      act_en_d   = pnd_en_q;
    end
  end

`ifdef SEG_LZ_BLANK_EN
  // Walk from the top digit down; a digit stays suppressed while every enabled
  // nibble from it upwards is zero. Digit 0 is always shown.
  logic zero_run;
  always_comb begin
    zero_run = 1'b1;
    sup      = '0;
    for (int n = 7; n >= 0; n--) begin
      if (act_en_q[n] && (act_data_q[4*n +: 4] != 4'h0)) begin
        zero_run = 1'b0;
      end
      if ((n > 0) && act_en_q[n] && zero_run) begin
        sup[n] = 1'b1;
      end
    end
  end
`else
  assign sup = '0;
`endif

  // Display outputs, registered from the current scan state.
  always_comb begin
    nib   = act_data_q[{idx_q, 2'b00} +: 4];
    an_d  = 8'hFF;
    seg_d = sup[idx_q] ? 7'h7F : hex_decode(nib);
    dp_d  = ~act_dp_q[idx_q];
    if (!blank && act_en_q[idx_q] && (!sup[idx_q] || act_dp_q[idx_q])) begin
      an_d[idx_q] = 1'b0;
    end
  end

  always_ff @(posedge CLK100_I or posedge RST_I) begin
    if (RST_I) begin
      presc_q    <= '0;
      idx_q      <= '0;
      pnd_data_q <= '0;
      pnd_dp_q   <= '0;
      pnd_en_q   <= '0;
      pend_q     <= 1'b0;
      act_data_q <= '0;
      act_dp_q   <= '0;
      act_en_q   <= '0;
      an_q       <= 8'hFF;
      seg_q      <= 7'h7F;
      dp_q       <= 1'b1;
      frame_q    <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      idx_q      <= idx_d;
      pnd_data_q <= pnd_data_d;
      pnd_dp_q   <= pnd_dp_d;
      pnd_en_q   <= pnd_en_d;
      pend_q     <= pend_d;
      act_data_q <= act_data_d;
      act_dp_q   <= act_dp_d;
      act_en_q   <= act_en_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      frame_q    <= frame_d;
    end
  end

  assign AN_O    = an_q;
  assign SEG_O   = seg_q;
  assign DP_O    = dp_q;
  assign PEND_O  = pend_q;
  assign FRAME_O = frame_q;

endmodule

// File: tb/tb_seg_display_cont.sv
// Self-checking bench for seg_display_cont: directed scenarios plus random loads,
// compared every cycle against a cycle-count based reference model.
module tb_seg_display_cont;

  localparam int unsigned RD = 16;
  localparam int unsigned BC = 2;
  localparam int unsigned FRAME_CYC = RD * 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data_i;
  logic [7:0]  dp_i;
  logic [7:0]  en_i;
  logic        load_i;
  logic [7:0]  an_o;
  logic [6:0]  seg_o;
  logic        dp_o;
  logic        pend_o;
  logic        frame_o;

  seg_display_cont #(
    .REFRESH_DIV(RD),
    .BLANK_CYC  (BC)
  ) dut (
    .CLK100_I(clk),
    .RST_I   (rst),
    .DATA_I  (data_i),
    .DP_I    (dp_i),
    .EN_I    (en_i),
    .LOAD_I  (load_i),
    .AN_O    (an_o),
    .SEG_O   (seg_o),
    .DP_O    (dp_o),
    .PEND_O  (pend_o),
    .FRAME_O (frame_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: time since reset plus the two buffers.
  int unsigned cnt;
  logic [31:0] m_act_data, m_pnd_data;
  logic [7:0]  m_act_dp, m_pnd_dp, m_act_en, m_pnd_en;
  logic        m_pend;
  logic [7:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp, e_frame;
  logic [6:0]  hex_tab [16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cnt);
    end
  endtask

  task automatic model_reset();
    cnt = 0;
    m_act_data = '0; m_act_dp = '0; m_act_en = '0;
    m_pnd_data = '0; m_pnd_dp = '0; m_pnd_en = '0;
    m_pend = 1'b0;
  endtask

  task automatic model_edge(input logic ld, input logic [31:0] d, input logic [7:0] dp,
                            input logic [7:0] en);
    int unsigned presc, idx;
    logic [7:0]  sup;
    logic        zr;
    presc = cnt % RD;
    idx   = (cnt / RD) % 8;
    sup   = '0;
`ifdef SEG_LZ_BLANK_EN
    for (int n = 1; n < 8; n++) begin
      if (m_act_en[n]) begin
        zr = 1'b1;
        for (int m = n; m < 8; m++) begin
          if (m_act_en[m] && (m_act_data[4*m +: 4] != 4'h0)) zr = 1'b0;
        end
        sup[n] = zr;
      end
    end
`else
    zr = 1'b0;
`endif
    e_an = 8'hFF;
    if (presc >= BC && m_act_en[idx] && (!sup[idx] || m_act_dp[idx])) e_an[idx] = 1'b0;
    e_seg   = sup[idx] ? 7'h7F : hex_tab[m_act_data[4*idx +: 4]];
    e_dp    = ~m_act_dp[idx];
    e_frame = (presc == RD - 1) && (idx == 7);
    if (e_frame && m_pend) begin
      m_act_data = m_pnd_data; m_act_dp = m_pnd_dp; m_act_en = m_pnd_en;
      m_pend = 1'b0;
    end
    if (ld) begin
      m_pnd_data = d; m_pnd_dp = dp; m_pnd_en = en;
      m_pend = 1'b1;
    end
    cnt++;
  endtask

  // One clock: drive at negedge, model the posedge, compare at the next negedge.
  task automatic cyc(input logic ld, input logic [31:0] d, input logic [7:0] dp,
                     input logic [7:0] en);
    load_i = ld; data_i = d; dp_i = dp; en_i = en;
    @(posedge clk);
    model_edge(ld, d, dp, en);
    @(negedge clk);
    load_i = 1'b0;
    data_i = $urandom; dp_i = 8'($urandom); en_i = 8'($urandom);
    chk("an", 32'(an_o), 32'(e_an));
    chk("seg", 32'(seg_o), 32'(e_seg));
    chk("dp", 32'(dp_o), 32'(e_dp));
    chk("pend", 32'(pend_o), 32'(m_pend));
    chk("frame", 32'(frame_o), 32'(e_frame));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, $urandom, 8'($urandom), 8'($urandom));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_an"}, 32'(an_o), 32'hFF);
    chk({tag, "_seg"}, 32'(seg_o), 32'h7F);
    chk({tag, "_dp"}, 32'(dp_o), 32'h1);
    chk({tag, "_pend"}, 32'(pend_o), 32'h0);
    chk({tag, "_frame"}, 32'(frame_o), 32'h0);
  endtask

  task automatic to_boundary();
    while (cnt % FRAME_CYC != FRAME_CYC - 1) idle(1);
  endtask

  initial begin
    hex_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    rst = 1'b1; load_i = 1'b0; data_i = '0; dp_i = '0; en_i = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("rst_hold");
    rst = 1'b0;
    check_reset_outputs("rst_release");

    // Basic display
    cyc(1'b1, 32'h89AB_CDEF, 8'h00, 8'hFF);
    chk("basic_pend", 32'(pend_o), 32'h1);
    idle(3 * FRAME_CYC);

    // Double load: last one wins
    cyc(1'b1, 32'h0000_0001, 8'h00, 8'hFF);
    idle(5);
    cyc(1'b1, 32'h0000_0002, 8'h00, 8'hFF);
    idle(2 * FRAME_CYC);

    // Load coinciding with the frame boundary
    cyc(1'b1, 32'h0000_0005, 8'h00, 8'hFF);
    to_boundary();
    cyc(1'b1, 32'h0000_0006, 8'h00, 8'hFF);
    chk("bnd_pend_stays", 32'(pend_o), 32'h1);
    chk("bnd_frame", 32'(frame_o), 32'h1);
    idle(2 * FRAME_CYC);

    // Load on a boundary with nothing pending
    to_boundary();
    cyc(1'b1, 32'h0000_0007, 8'h01, 8'h0F);
    idle(2 * FRAME_CYC);

    // Enable mask and decimal point
    cyc(1'b1, 32'h1234_5678, 8'h02, 8'h0F);
    idle(2 * FRAME_CYC);

    // Leading zeros
    cyc(1'b1, 32'h0000_0120, 8'h00, 8'hFF);
    idle(2 * FRAME_CYC);
    cyc(1'b1, 32'h0000_0000, 8'h84, 8'hFF);
    idle(2 * FRAME_CYC);

    // Random loads at random times
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, $urandom, 8'($urandom), 8'($urandom));
      idle(int'($urandom_range(0, 300)));
    end

    // Reset asserted mid-frame
    cyc(1'b1, 32'hDEAD_BEEF, 8'hFF, 8'hFF);
    idle(FRAME_CYC + 40);
    #2 rst = 1'b1;
    #1 check_reset_outputs("rst_mid");
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_outputs("rst_mid_hold");
    rst = 1'b0;
    idle(2 * FRAME_CYC);
    cyc(1'b1, 32'hFEDC_BA98, 8'h55, 8'hFF);
    idle(2 * FRAME_CYC);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_display_cont.md
SEG_DISPLAY_CONT -- requirements
Module: seg_display_cont

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-high (CLK100_I, RST_I).
REQ-002 Parameter REFRESH_DIV, default 100000: clock cycles per digit slot (1 kHz per digit at 100 MHz). Legal range is 16 or more.
REQ-003 Parameter BLANK_CYC, default 4: cycles at the start of each slot with all anodes off. Legal range is 1 to REFRESH_DIV-1.
REQ-004 CLK100_I  in  1  100 MHz board clock.
REQ-005 RST_I  in  1  asynchronous active-high reset.
REQ-006 DATA_I  in  32  eight hex nibbles; nibble n is shown on digit n.
REQ-007 DP_I  in  8  decimal-point request per digit, active-high.
REQ-008 EN_I  in  8  digit enable mask, active-high.
REQ-009 LOAD_I  in  1  single-cycle strobe that captures DATA_I, DP_I and EN_I into the pending buffer.
REQ-010 AN_O  out  8  digit anodes, active-low.
REQ-011 SEG_O  out  7  segments CA..CG as bits [0]..[6], active-low.
REQ-012 DP_O  out  1  decimal point, active-low.
REQ-013 PEND_O  out  1  high while the pending buffer holds data not yet committed.
REQ-014 FRAME_O  out  1  one-cycle pulse on each frame commit boundary.

Function
REQ-015 The prescaler SHALL count 0..REFRESH_DIV-1 and wrap. On the wrap cycle the digit index SHALL increment modulo 8.
REQ-016 The frame boundary is the wrap cycle with index 7 -> 0. On that edge the pending buffer SHALL commit to the active registers if PEND_O=1, PEND_O SHALL clear, and FRAME_O SHALL pulse whether or not a commit occurred.
REQ-017 Loads:
- LOAD_I=1 SHALL write the pending buffer and set PEND_O on the same edge.
- A repeated LOAD before commit SHALL overwrite the pending contents; the last load wins.
REQ-018 If LOAD_I coincides with a frame boundary:
- The commit SHALL use the pending contents held before that edge.
- The new data SHALL go into the pending buffer.
- PEND_O SHALL remain 1.
REQ-019 If LOAD_I coincides with a frame boundary while PEND_O=0, nothing SHALL be committed, the new data SHALL be pending, and PEND_O SHALL be 1.
REQ-020 Anode gating: during prescaler counts 0..BLANK_CYC-1, AN_O SHALL be 8'hFF.
REQ-021 After the blanking window, AN_O[idx] SHALL be 0 only if active EN[idx]=1, and all other anode bits SHALL be 1.
REQ-022 SEG_O SHALL be the standard hex decode of active nibble idx. Required patterns (active-low, bits [6:0]):
- 0 = 7'h40, 1 = 7'h79, 2 = 7'h24, 3 = 7'h30
- 4 = 7'h19, 5 = 7'h12, 6 = 7'h02, 7 = 7'h78
- 8 = 7'h00, 9 = 7'h10, A = 7'h08, b = 7'h03
- C = 7'h46, d = 7'h21, E = 7'h06, F = 7'h0E
REQ-023 DP_O SHALL be ~active DP[idx].
REQ-024 AN_O, SEG_O and DP_O SHALL be registered, with one cycle of latency from the prescaler/index state.
REQ-025 A disabled digit SHALL keep its anode off for the whole slot; its slot time SHALL still elapse, so scan timing is fixed.
REQ-026 Active registers SHALL never change except at a frame boundary, so no frame shows a partial update.

Reset
REQ-027 While RST_I=1 and on its release, the block SHALL hold:
- AN_O=8'hFF, SEG_O=7'h7F, DP_O=1
- PEND_O=0, FRAME_O=0
- prescaler=0, index=0
- active and pending registers = 0
REQ-028 Reset asserted mid-frame SHALL discard pending data, and the display SHALL stay dark until the first commit after a load.

Configuration
REQ-029 Macro SEG_LZ_BLANK_EN selects leading-zero suppression.
REQ-030 With SEG_LZ_BLANK_EN defined:
- An enabled digit n>0 whose nibble and all higher enabled nibbles are 0 SHALL be suppressed.
- A suppressed digit SHALL have its anode off unless its active DP bit is 1; if that bit is 1, the anode SHALL be on with SEG_O=7'h7F.
- Digit 0 SHALL never be suppressed.
REQ-031 Without SEG_LZ_BLANK_EN, every enabled digit SHALL display its nibble, including leading zeros.
REQ-032 The macro SHALL add no ports, and scan timing SHALL be identical in both builds.

Verification
REQ-033 Basic display, REFRESH_DIV=16, BLANK_CYC=2:
- Stimulus: reset, then LOAD 32'h89AB_CDEF, EN=8'hFF, DP=8'h00.
- Response: PEND_O=1 until the first FRAME_O, then AN_O cycles FE, FD, ..., 7F with 16-cycle slots, each slot's first 2 cycles at 8'hFF, and digit 0 SEG_O=7'h0E.
REQ-034 Double load:
- Stimulus: LOAD 32'h1, then LOAD 32'h2 before the boundary.
- Response: only 32'h2 is ever displayed.
REQ-035 Load on boundary:
- Stimulus: pending 32'h5, and LOAD 32'h6 on the boundary edge.
- Response: 5 is shown in the next frame, PEND_O stays 1, and 6 is shown in the following frame.
REQ-036 Enable mask and DP:
- Stimulus: EN=8'h0F, DP=8'h02.
- Response: AN_O[7:4] stays 1 always, and DP_O=0 only during the digit 1 slot.
REQ-037 Leading-zero suppression, SEG_LZ_BLANK_EN defined:
- Stimulus: DATA 32'h0000_0120, EN=8'hFF.
- Response: digits 7..3 are dark, and digits 2..0 show "1", "2", "0".
- Without the macro, all eight digits light.
REQ-038 Reset mid-frame:
- Stimulus: assert RST_I mid-frame.
- Response: immediate AN_O=8'hFF and PEND_O=0, then dark until a new load commits.
